// File: rtl/index_packer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// index_packer
// Transmit side of the PE index-batch interface. It takes one tile header
// (the nonzero count), then a serial stream of (row, col) nonzero indices.
// It packs these into PE_NUMBER-lane batches and issues each batch together
// with the count of entries still outstanding in the tile. The index parser
// downstream uses that count to build its lane masks.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_tile_valid / o_tile_ready         tile header handshake (ready only in IDLE)
//   i_tile_nnz   [RW-1:0]               nonzeros in the tile
//   i_idx_valid / o_idx_ready           index entry handshake (ready only in FILL)
//   i_row [LOG2_HEIGHT-1:0]             entry row index
//   i_col [LOG2_PES-1:0]                entry column index
//   o_batch_valid / i_batch_ready       batch handshake (valid only in SEND)
//   o_row_index  [PE_NUMBER*LOG2_HEIGHT-1:0]   lane k row at [k*LOG2_HEIGHT +: LOG2_HEIGHT]
//   o_col_index  [PE_NUMBER*LOG2_PES-1:0]      lane k col at [k*LOG2_PES +: LOG2_PES]
//   o_remain_count [RW-1:0]             entries left in tile, including this batch
//   o_tile_done                         one-cycle pulse once the tile is fully issued
// ---------------------------------------------------------------------------
module index_packer #(
    parameter int PE_NUMBER   = 32,
    parameter int LOG2_HEIGHT = 4,
    parameter int LOG2_PES    = 5,
    parameter int LOG2_K      = 5,
    localparam int RW         = LOG2_HEIGHT + LOG2_K
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_tile_valid,
    output logic                             o_tile_ready,
    input  logic [RW-1:0]                    i_tile_nnz,
    input  logic                             i_idx_valid,
    output logic                             o_idx_ready,
    input  logic [LOG2_HEIGHT-1:0]           i_row,
    input  logic [LOG2_PES-1:0]              i_col,
    output logic                             o_batch_valid,
    input  logic                             i_batch_ready,
    output logic [PE_NUMBER*LOG2_HEIGHT-1:0] o_row_index,
    output logic [PE_NUMBER*LOG2_PES-1:0]    o_col_index,
    output logic [RW-1:0]                    o_remain_count,
    output logic                             o_tile_done
);

    localparam int FW = $clog2(PE_NUMBER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]                     r_state;
    // Low during reset, set on the first clock after release so that
    // o_tile_ready only rises once reset has been released.
    logic                           r_alive;
    logic [FW-1:0]                  r_fill_cnt;
    logic [RW-1:0]                  r_remain;
    logic [PE_NUMBER*LOG2_HEIGHT-1:0] r_row_index;
    logic [PE_NUMBER*LOG2_PES-1:0]  r_col_index;
    logic                           r_tile_done;

    logic [FW-1:0]                  w_target;
    logic [FW-1:0]                  w_fill_inc;
    logic [RW-1:0]                  w_fill_ext;
    logic [RW-1:0]                  w_remain_next;

    // Lanes needed for the batch being filled: a full batch unless the tile
    // has fewer entries left than there are lanes.
    assign w_target      = (r_remain >= RW'(PE_NUMBER)) ? FW'(PE_NUMBER) : r_remain[FW-1:0];
    assign w_fill_inc    = r_fill_cnt + FW'(1);
    assign w_fill_ext    = {{(RW-FW){1'b0}}, r_fill_cnt};
    assign w_remain_next = (r_remain > w_fill_ext) ? (r_remain - w_fill_ext) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_alive     <= 1'b0;
            r_fill_cnt  <= '0;
            r_remain    <= '0;
            r_row_index <= '0;
            r_col_index <= '0;
            r_tile_done <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_tile_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_tile_valid && r_alive) begin
                        r_remain    <= i_tile_nnz;
                        r_fill_cnt  <= '0;
                        r_row_index <= '0;
                        r_col_index <= '0;
                        // An empty tile issues no batch, only the done pulse.
                        if (i_tile_nnz != '0) begin
                            r_state <= S_FILL;
                        end else begin
                            r_tile_done <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (i_idx_valid) begin
                        for (int k = 0; k < PE_NUMBER; k++) begin
                            if (r_fill_cnt == FW'(k)) begin
                                r_row_index[k*LOG2_HEIGHT +: LOG2_HEIGHT] <= i_row;
                                r_col_index[k*LOG2_PES +: LOG2_PES]       <= i_col;
                            end
                        end
                        r_fill_cnt <= w_fill_inc;
                        if (w_fill_inc == w_target) begin
                            r_state <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (i_batch_ready) begin
                        r_remain    <= w_remain_next;
                        r_fill_cnt  <= '0;
                        r_row_index <= '0;
                        r_col_index <= '0;
                        if (w_remain_next == '0) begin
                            r_state     <= S_IDLE;
                            r_tile_done <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from state; lane data comes from
    // registers that are cleared between batches, so unfilled lanes read 0.
    assign o_tile_ready   = r_alive && (r_state == S_IDLE);
    assign o_idx_ready    = (r_state == S_FILL);
    assign o_batch_valid  = (r_state == S_SEND);
    assign o_remain_count = o_batch_valid ? r_remain : '0;
    assign o_row_index    = r_row_index;
    assign o_col_index    = r_col_index;
    assign o_tile_done    = r_tile_done;

endmodule
